retire_trace_fifo: RTL
======================

Name: retire_trace_fifo

Overview:
- Sits directly downstream of the single-cycle core's per-instruction debug record (pc, decode fields, result, data-memory activity).
- Captures one record per retired instruction, within a configurable trigger/limit window.
- Buffers captured records in a FIFO and drains them to a trace sink over a valid/ready handshake.
- Drop-on-full policy, with a drop counter and sticky overflow flag, so the core is never stalled.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- SEQ_W, 16, width of the sequence-number field.
- TRACE_W, 189+SEQ_W, packed record width; derived, do not override.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- cfg_en  in  1  capture enable; 0 forces IDLE
- cfg_trig_en  in  1  1 = wait for cfg_trig_pc before capturing
- cfg_trig_pc  in  32  trigger PC
- cfg_limit  in  16  records to capture after trigger; 0 = unlimited
- ret_valid  in  1  instruction retired this cycle
- ret_pc  in  32  retired PC
- ret_op  in  7  opcode
- ret_funct3  in  3  funct3
- ret_sub  in  1  alu_sub_funct7 bit
- ret_rs1, ret_rs2, ret_rd  in  5 each  register indices
- ret_result  in  32  ALU/writeback result
- ret_dmem_we  in  1  store
- ret_dmem_addr  in  32  data address
- ret_dmem_wd  in  32  store data
- ret_dmem_rd  in  32  load data
- ret_regwrite, ret_memtoreg  in  1 each  control bits
- trace_valid  out  1  FIFO head valid
- trace_ready  in  1  sink accepts head
- trace_data  out  TRACE_W  packed head record
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- overflow  out  1  sticky: a record was dropped
- drop_cnt  out  16  saturating dropped-record count

Behaviour:
- Reset (sync, high):
  - state=IDLE, FIFO emptied, fifo_count=0, trace_valid=0, trace_data=0.
  - overflow=0, drop_cnt=0, seq=0, capture counter=0.
  - Reset mid-drain discards all entries.
- Record packing, MSB→LSB:
  - seq[SEQ_W], pc[32], op[7], funct3[3], sub[1], rs1[5], rs2[5], rd[5], result[32], dmem_we[1], dmem_addr[32], dmem_wd[32], dmem_rd[32], regwrite[1], memtoreg[1].
- State machine:
  - IDLE→ARMED when cfg_en=1.
    - On this transition: cfg_trig_en, cfg_trig_pc and cfg_limit are latched; seq and the capture counter clear to 0; overflow and drop_cnt also clear.
  - ARMED: a retire "hits" when ret_valid && (!trig_en_l || ret_pc==trig_pc_l).
    - The hitting record itself is captured.
    - Next state is DONE if limit_l==1, else CAPTURE.
    - Non-hitting retires are not captured.
  - CAPTURE: every ret_valid is one considered record (pushed or dropped), and the capture counter increments.
    - When the counter reaches limit_l (limit_l≠0), go to DONE on that cycle's edge; the last record is still pushed.
  - DONE: no capture. FIFO still drains. Stays until cfg_en=0.
  - Any state→IDLE when cfg_en=0. cfg_en=0 has priority over a same-cycle hit or push.
  - FIFO contents survive IDLE and continue draining.
- seq increments on every ret_valid while state≠IDLE, captured or not, and wraps mod 2^SEQ_W.
  - The pushed record carries the pre-increment value.
  - Gaps in seq at the sink therefore expose both drops and filtered retires.
- FIFO:
  - Push is registered: a record pushed in cycle N appears on trace_data with trace_valid=1 in cycle N+1 if the FIFO was empty.
  - Pop occurs when trace_valid && trace_ready.
  - trace_data/trace_valid are stable while trace_valid=1 and trace_ready=0.
  - Full with a simultaneous pop: the push is accepted and the count is unchanged.
  - Full without a pop: the record is dropped, overflow←1, drop_cnt+1 saturating at 0xFFFF.
  - Empty with a simultaneous push and ready: no bypass; the pop is ignored and the record appears next cycle.
  - Pointers wrap mod DEPTH; fifo_count ranges 0..DEPTH.
- ret_valid=0 has no effect apart from the FIFO pop side.

Test Plan:
- Reset, cfg_en=1, trig_en=0, limit=0, ret_valid at pc 0x0,0x4,0x8, ready=1 → three records out in order, seq 0,1,2, first trace_valid exactly 1 cycle after the first retire.
- trig_en=1, trig_pc=0x20, retires at 0x18,0x1C,0x20,0x24 → state 1→2 on 0x20; only 0x20 (seq 2) and 0x24 (seq 3) are captured.
- limit=3, trig_en=0, 5 retires → 3 records, state=3 after the third retire, fifo_count=3 with ready=0.
- DEPTH=16, ready=0, 20 retires → fifo_count=16, drop_cnt=4, overflow=1; then ready=1 → seq 0..15 drained, trace_valid falls after the 16th pop.
- FIFO full, same-cycle retire and ready=1 → fifo_count stays 16, drop_cnt unchanged, the new record is last out.
- 3 records queued, then cfg_en=0 → state=0, 3 records still drain; re-enabling clears drop_cnt/overflow and restarts seq at 0; reset asserted mid-drain → trace_valid=0 and fifo_count=0 the next cycle.

Source files
------------

// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: windowed capture of retired-instruction records into a drop-on-full FIFO
// drained over valid/ready; the core is never stalled.
module retire_trace_fifo #(
    parameter int DEPTH   = 16,
    parameter int SEQ_W   = 16,
    parameter int TRACE_W = 189 + SEQ_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_en,
    input  logic                       cfg_trig_en,
    input  logic [31:0]                cfg_trig_pc,
    input  logic [15:0]                cfg_limit,
    input  logic                       ret_valid,
    input  logic [31:0]                ret_pc,
    input  logic [6:0]                 ret_op,
    input  logic [2:0]                 ret_funct3,
    input  logic                       ret_sub,
    input  logic [4:0]                 ret_rs1,
    input  logic [4:0]                 ret_rs2,
    input  logic [4:0]                 ret_rd,
    input  logic [31:0]                ret_result,
    input  logic                       ret_dmem_we,
    input  logic [31:0]                ret_dmem_addr,
    input  logic [31:0]                ret_dmem_wd,
    input  logic [31:0]                ret_dmem_rd,
    input  logic                       ret_regwrite,
    input  logic                       ret_memtoreg,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [TRACE_W-1:0]         trace_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [1:0]                 state,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    state_t st;
    logic trig_en_l;
    logic [31:0] trig_pc_l;
    logic [15:0] limit_l, cap_cnt, cap_next;
    logic [SEQ_W-1:0] seq;
    logic [TRACE_W-1:0] mem [DEPTH];
    logic [TRACE_W-1:0] rec;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic hit, push_req, push, pop, full;
    assign state = st;
    assign rec = {seq, ret_pc, ret_op, ret_funct3, ret_sub, ret_rs1, ret_rs2, ret_rd, ret_result,
                  ret_dmem_we, ret_dmem_addr, ret_dmem_wd, ret_dmem_rd, ret_regwrite, ret_memtoreg};
    assign trace_valid = fifo_count != '0;
    assign trace_data = trace_valid ? mem[rd_ptr] : '0;
    always_comb begin
        hit = ret_valid && (!trig_en_l || ret_pc == trig_pc_l);
        push_req = cfg_en && ((st == ARMED && hit) || (st == CAPTURE && ret_valid));
        pop = trace_valid && trace_ready;
        full = fifo_count == (AW+1)'(DEPTH);
        push = push_req && (!full || pop);
        cap_next = cap_cnt + 16'd1;
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= rec;
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            seq <= '0;
            cap_cnt <= '0;
            trig_en_l <= 1'b0;
            trig_pc_l <= '0;
            limit_l <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (push_req && !push) begin
                overflow <= 1'b1;
                drop_cnt <= drop_cnt + {15'd0, drop_cnt != 16'hFFFF};
            end
            if (st != IDLE && ret_valid) seq <= seq + 1'b1;
            if (!cfg_en) st <= IDLE;
            else if (st == IDLE) begin
                st <= ARMED;
                trig_en_l <= cfg_trig_en;
                trig_pc_l <= cfg_trig_pc;
                limit_l <= cfg_limit;
                seq <= '0;
                cap_cnt <= '0;
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (st == ARMED && hit) begin
                cap_cnt <= 16'd1;
                st <= limit_l == 16'd1 ? DONE : CAPTURE;
            end else if (st == CAPTURE && ret_valid) begin
                cap_cnt <= cap_next;
                if (limit_l != '0 && cap_next == limit_l) st <= DONE;
            end
        end
    end
endmodule
